order_book_levels: RTL and testbench
====================================

Name: order_book_levels

Overview:
- Parametrised successor of the top-of-book tracker: a full price-level book per side, sorted and DEPTH levels deep.
- Supports aggregate add, reduce/delete at any level and clears, rather than only inserting improving prices.
- Sits after the market-data decoder, one instance per symbol. Feeds the strategy/TOB consumers with registered best bid/ask, level counts and change pulses.
- Uses a valid/ready input handshake with a 3-state FSM.

Parameters:
- DEPTH, 16, levels held per side (>=2).
- PRICE_W, 32, price width (unsigned ticks).
- QTY_W, 32, quantity width (unsigned).
- CNT_W, $clog2(DEPTH+1), width of level-count outputs (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  update request
- in_ready  out  1  block can accept an update this cycle
- in_op  in  2  0=ADD, 1=REDUCE, 2=CLEAR_SIDE, 3=CLEAR_ALL
- in_side  in  1  0=bid, 1=ask (ignored for CLEAR_ALL)
- in_price  in  PRICE_W  level price
- in_qty  in  QTY_W  quantity delta
- best_bid_price  out  PRICE_W  level-0 bid price
- best_bid_qty  out  QTY_W  level-0 bid quantity
- best_ask_price  out  PRICE_W  level-0 ask price
- best_ask_qty  out  QTY_W  level-0 ask quantity
- bid_levels  out  CNT_W  occupied bid levels
- ask_levels  out  CNT_W  occupied ask levels
- tob_valid  out  1  both sides non-empty
- tob_changed  out  1  one-cycle pulse when any best_* output changes
- update_count  out  32  accepted updates
- drop_count  out  32  updates with no effect

Behaviour:
Reset (asynchronous, any state):
- FSM goes to IDLE; an in-flight update is discarded.
- Bid levels: price 0, qty 0. Ask levels: price all-ones, qty 0.
- best_bid_* = 0. best_ask_price = all-ones. best_ask_qty = 0.
- Level counts 0; tob_valid 0; tob_changed 0; both counters 0.
- in_ready = 1 once rst is low.

FSM (IDLE -> CMP -> APPLY -> IDLE):
- IDLE: in_ready = 1. When in_valid is high, latch op/side/price/qty and go to CMP.
- CMP: in_ready = 0. Over occupied levels (index < count) compute:
  - match index k: first level with price == in_price.
  - insert index p: first level with a worse price (bid: in_price > lvl; ask: in_price < lvl), else p = count.
  - Register both; go to APPLY.
- APPLY: in_ready = 0. Update the arrays, best_*, counts, tob_valid, tob_changed and counters on the same edge; go to IDLE.
- Throughput: one update per 3 cycles. Latency: accept edge N, results visible after edge N+2.
- Occupancy is decided only by the count, never by sentinel values. Sorting: bid strictly descending, ask strictly ascending, no duplicate prices.

ADD:
- in_qty == 0: no change, drop.
- Match k: qty[k] += in_qty, saturating at all-ones.
- No match, p < DEPTH: shift levels p..DEPTH-2 down by one, write (in_price, in_qty) at p.
  - count = min(count+1, DEPTH).
  - When full, the old level DEPTH-1 is evicted silently; this is not a drop.
- No match, p == DEPTH (full and worse than every level): drop.

REDUCE:
- No match: drop.
- in_qty >= qty[k]: delete level k. Shift k+1..count-1 up, write the sentinel at count-1, count-1.
- Otherwise: qty[k] -= in_qty.

CLEAR_SIDE and CLEAR_ALL:
- CLEAR_SIDE returns the selected side to its reset contents; CLEAR_ALL does this for both sides.
- Neither counts as a drop, even when the side is already empty.

Status and counters:
- update_count += 1 at APPLY for every accepted update. drop_count += 1 at APPLY on a drop. Both wrap modulo 2^32.
- tob_valid = (bid count != 0) && (ask count != 0), using the post-update counts.
- tob_changed = 1 for exactly the APPLY cycle if any best_* value differs from its pre-update value; otherwise 0.
- Crossed books (best bid >= best ask) are stored as given, with no matching.
- in_valid while in_ready = 0 is ignored; the source must hold the request.

Test Plan (DEPTH=4):
- After reset: in_ready=1, best_ask_price=FFFFFFFF, all counts 0. Then ADD bid 100/5 -> 3 cycles later best_bid=100/5, bid_levels=1, tob_changed pulse, tob_valid=0, update_count=1.
- ADD bids 100/5, 102/3, 101/7, 100/2 -> bid order 102,101,100; qty at 100 = 7; bid_levels=3; best_bid=102/3.
- Fill bids 104,103,102,101, then ADD bid 105/1 -> 101 evicted, best=105, bid_levels=4, drop_count unchanged. Then ADD bid 99/1 -> drop_count+1, book unchanged.
- Asks 200/4, 201/6: REDUCE 200/1 -> best_ask_qty=3. REDUCE 200/10 -> best_ask=201/6, ask_levels=1. REDUCE 250/1 -> drop_count+1.
- One bid and one ask present (tob_valid=1): CLEAR_SIDE ask -> ask_levels=0, best_ask_price=FFFFFFFF, tob_valid=0. Then CLEAR_ALL -> all counts 0. Saturation: ADD qty FFFFFFF0 then +0x20 at the same price -> qty FFFFFFFF.
- Assert rst during CMP -> no array change, counters 0, in_ready=1 on the first cycle after rst deasserts. Also: in_valid held high while in_ready=0 -> only one update accepted per 3 cycles.

Source files
------------

// File: rtl/order_book_levels_if.sv
`default_nettype none
// ============================================================================
// Module      : order_book_levels_if
// Description : Update request channel (valid/ready) into the per-symbol book.
// Revision    : 1.0  initial release
// ============================================================================
interface order_book_levels_if #(
    parameter int PRICE_W = 32,
    parameter int QTY_W   = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_op;
    logic               in_side;
    logic [PRICE_W-1:0] in_price;
    logic [QTY_W-1:0]   in_qty;

    modport master (output in_valid, in_op, in_side, in_price, in_qty, input in_ready);
    modport slave  (input in_valid, in_op, in_side, in_price, in_qty, output in_ready);
endinterface
`default_nettype wire

// File: rtl/order_book_levels.sv
`default_nettype none
// ============================================================================
// Module      : order_book_levels
// Description : Sorted DEPTH-level bid/ask price book with aggregate add,
//               reduce/delete and clears; registered top-of-book outputs.
// Revision    : 1.0  initial release
// ============================================================================
module order_book_levels #(
    parameter int DEPTH   = 16,
    parameter int PRICE_W = 32,
    parameter int QTY_W   = 32,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    order_book_levels_if.slave  in_if,
    output logic [PRICE_W-1:0]  best_bid_price,
    output logic [QTY_W-1:0]    best_bid_qty,
    output logic [PRICE_W-1:0]  best_ask_price,
    output logic [QTY_W-1:0]    best_ask_qty,
    output logic [CNT_W-1:0]    bid_levels,
    output logic [CNT_W-1:0]    ask_levels,
    output logic                tob_valid,
    output logic                tob_changed,
    output logic [31:0]         update_count,
    output logic [31:0]         drop_count
);
    localparam int              c_idx_w       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_depth      = CNT_W'(DEPTH);
    localparam logic [1:0]      c_op_add      = 2'd0;
    localparam logic [1:0]      c_op_reduce   = 2'd1;
    localparam logic [1:0]      c_op_clear_all = 2'd3;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CMP = 2'd1, S_APPLY = 2'd2} state_t;

    state_t                             state_q, state_d;
    logic [1:0]                         op_q, op_d;
    logic                               side_q, side_d;
    logic [PRICE_W-1:0]                 price_q, price_d;
    logic [QTY_W-1:0]                   qty_q, qty_d;
    logic                               match_q, match_d;
    logic [CNT_W-1:0]                   k_q, k_d, p_q, p_d;
    logic [DEPTH-1:0][PRICE_W-1:0]      bid_px_q, bid_px_d, ask_px_q, ask_px_d;
    logic [DEPTH-1:0][QTY_W-1:0]        bid_qty_q, bid_qty_d, ask_qty_q, ask_qty_d;
    logic [CNT_W-1:0]                   bid_cnt_q, bid_cnt_d, ask_cnt_q, ask_cnt_d;
    logic                               tob_changed_q, tob_changed_d;
    logic [31:0]                        update_count_q, update_count_d;
    logic [31:0]                        drop_count_q, drop_count_d;

    logic [DEPTH-1:0][PRICE_W-1:0]      cur_px, new_px;
    logic [DEPTH-1:0][QTY_W-1:0]        cur_qty, new_qty;
    logic [CNT_W-1:0]                   cur_cnt, new_cnt, last, hit_idx, ins_idx;
    logic [PRICE_W-1:0]                 sent_px;
    logic [c_idx_w-1:0]                 k_idx, p_idx, last_idx;
    logic [QTY_W:0]                     sum;
    logic                               hit, ins_found, drop;

    assign in_if.in_ready = (state_q == S_IDLE);

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        side_d         = side_q;
        price_d        = price_q;
        qty_d          = qty_q;
        match_d        = match_q;
        k_d            = k_q;
        p_d            = p_q;
        bid_px_d       = bid_px_q;
        bid_qty_d      = bid_qty_q;
        bid_cnt_d      = bid_cnt_q;
        ask_px_d       = ask_px_q;
        ask_qty_d      = ask_qty_q;
        ask_cnt_d      = ask_cnt_q;
        tob_changed_d  = 1'b0;
        update_count_d = update_count_q;
        drop_count_d   = drop_count_q;

        cur_px  = side_q ? ask_px_q  : bid_px_q;
        cur_qty = side_q ? ask_qty_q : bid_qty_q;
        cur_cnt = side_q ? ask_cnt_q : bid_cnt_q;
        sent_px = {PRICE_W{side_q}};

        // Only levels below the count are considered occupied.
        hit       = 1'b0;
        hit_idx   = '0;
        ins_found = 1'b0;
        ins_idx   = cur_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < cur_cnt) begin
                if (!hit && (cur_px[c_idx_w'(i)] == price_q)) begin
                    hit     = 1'b1;
                    hit_idx = CNT_W'(i);
                end
                if (!ins_found && (side_q ? (price_q < cur_px[c_idx_w'(i)])
                                          : (price_q > cur_px[c_idx_w'(i)]))) begin
                    ins_found = 1'b1;
                    ins_idx   = CNT_W'(i);
                end
            end
        end

        last     = cur_cnt - CNT_W'(1);
        k_idx    = k_q[c_idx_w-1:0];
        p_idx    = p_q[c_idx_w-1:0];
        last_idx = last[c_idx_w-1:0];
        sum      = {1'b0, cur_qty[k_idx]} + {1'b0, qty_q};
        new_px   = cur_px;
        new_qty  = cur_qty;
        new_cnt  = cur_cnt;
        drop     = 1'b0;

        case (op_q)
            c_op_add: begin
                if (qty_q == '0) begin
                    drop = 1'b1;
                end else if (match_q) begin
                    new_qty[k_idx] = sum[QTY_W] ? {QTY_W{1'b1}} : sum[QTY_W-1:0];
                end else if (p_q < c_depth) begin
                    // Shifting towards the tail drops the old last level when full.
                    for (int i = 1; i < DEPTH; i++) begin
                        if (CNT_W'(i) > p_q) begin
                            new_px[c_idx_w'(i)]  = cur_px[c_idx_w'(i - 1)];
                            new_qty[c_idx_w'(i)] = cur_qty[c_idx_w'(i - 1)];
                        end
                    end
                    new_px[p_idx]  = price_q;
                    new_qty[p_idx] = qty_q;
                    if (cur_cnt != c_depth) new_cnt = cur_cnt + CNT_W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
            c_op_reduce: begin
                if (!match_q) begin
                    drop = 1'b1;
                end else if (qty_q >= cur_qty[k_idx]) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        if ((CNT_W'(i) >= k_q) && (CNT_W'(i) < last)) begin
                            new_px[c_idx_w'(i)]  = cur_px[c_idx_w'(i + 1)];
                            new_qty[c_idx_w'(i)] = cur_qty[c_idx_w'(i + 1)];
                        end
                    end
                    new_px[last_idx]  = sent_px;
                    new_qty[last_idx] = '0;
                    new_cnt           = last;
                end else begin
                    new_qty[k_idx] = cur_qty[k_idx] - qty_q;
                end
            end
            default: begin
                new_px  = {DEPTH{sent_px}};
                new_qty = '0;
                new_cnt = '0;
            end
        endcase

        case (state_q)
            S_IDLE: begin
                if (in_if.in_valid) begin
                    op_d    = in_if.in_op;
                    side_d  = in_if.in_side;
                    price_d = in_if.in_price;
                    qty_d   = in_if.in_qty;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                match_d = hit;
                k_d     = hit_idx;
                p_d     = ins_idx;
                state_d = S_APPLY;
            end
            S_APPLY: begin
                if (op_q == c_op_clear_all) begin
                    bid_px_d  = '0;
                    bid_qty_d = '0;
                    bid_cnt_d = '0;
                    ask_px_d  = '1;
                    ask_qty_d = '0;
                    ask_cnt_d = '0;
                end else if (side_q) begin
                    ask_px_d  = new_px;
                    ask_qty_d = new_qty;
                    ask_cnt_d = new_cnt;
                end else begin
                    bid_px_d  = new_px;
                    bid_qty_d = new_qty;
                    bid_cnt_d = new_cnt;
                end
                update_count_d = update_count_q + 32'd1;
                if (drop) drop_count_d = drop_count_q + 32'd1;
                tob_changed_d = (bid_px_d[0]  != bid_px_q[0])  || (bid_qty_d[0] != bid_qty_q[0]) ||
                                (ask_px_d[0]  != ask_px_q[0])  || (ask_qty_d[0] != ask_qty_q[0]);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= '0;
            side_q         <= 1'b0;
            price_q        <= '0;
            qty_q          <= '0;
            match_q        <= 1'b0;
            k_q            <= '0;
            p_q            <= '0;
            bid_px_q       <= '0;
            bid_qty_q      <= '0;
            bid_cnt_q      <= '0;
            ask_px_q       <= '1;
            ask_qty_q      <= '0;
            ask_cnt_q      <= '0;
            tob_changed_q  <= 1'b0;
            update_count_q <= '0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            side_q         <= side_d;
            price_q        <= price_d;
            qty_q          <= qty_d;
            match_q        <= match_d;
            k_q            <= k_d;
            p_q            <= p_d;
            bid_px_q       <= bid_px_d;
            bid_qty_q      <= bid_qty_d;
            bid_cnt_q      <= bid_cnt_d;
            ask_px_q       <= ask_px_d;
            ask_qty_q      <= ask_qty_d;
            ask_cnt_q      <= ask_cnt_d;
            tob_changed_q  <= tob_changed_d;
            update_count_q <= update_count_d;
            drop_count_q   <= drop_count_d;
        end
    end

    assign best_bid_price = bid_px_q[0];
    assign best_bid_qty   = bid_qty_q[0];
    assign best_ask_price = ask_px_q[0];
    assign best_ask_qty   = ask_qty_q[0];
    assign bid_levels     = bid_cnt_q;
    assign ask_levels     = ask_cnt_q;
    assign tob_valid      = (bid_cnt_q != '0) && (ask_cnt_q != '0);
    assign tob_changed    = tob_changed_q;
    assign update_count   = update_count_q;
    assign drop_count     = drop_count_q;
endmodule
`default_nettype wire

// File: tb/tb_order_book_levels.sv
`default_nettype none
// ============================================================================
// Module      : tb_order_book_levels
// Description : Directed self-checking bench for order_book_levels (DEPTH=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_order_book_levels;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [1:0] ADD = 2'd0, RED = 2'd1, CLS = 2'd2, CLA = 2'd3;
    localparam logic BID = 1'b0, ASK = 1'b1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       best_bid_price, best_bid_qty, best_ask_price, best_ask_qty;
    logic [CNT_W-1:0]  bid_levels, ask_levels;
    logic              tob_valid, tob_changed;
    logic [31:0]       update_count, drop_count;

    int n_pass  = 0;
    int n_total = 0;
    int exp_upd = 0;
    int exp_drop = 0;

    order_book_levels_if #(.PRICE_W(32), .QTY_W(32)) bus ();

    order_book_levels #(.DEPTH(DEPTH), .PRICE_W(32), .QTY_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_if          (bus),
        .best_bid_price (best_bid_price),
        .best_bid_qty   (best_bid_qty),
        .best_ask_price (best_ask_price),
        .best_ask_qty   (best_ask_qty),
        .bid_levels     (bid_levels),
        .ask_levels     (ask_levels),
        .tob_valid      (tob_valid),
        .tob_changed    (tob_changed),
        .update_count   (update_count),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One full update: accept edge, then two more edges, then sample.
    task automatic send(input logic [1:0] op, input logic side, input logic [31:0] price,
                        input logic [31:0] qty, input bit is_drop);
        int waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_side  = side;
        bus.in_price = price;
        bus.in_qty   = qty;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_upd++;
        if (is_drop) exp_drop++;
        check("update_count", update_count, exp_upd);
        check("drop_count", drop_count, exp_drop);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_op    = ADD;
        bus.in_side  = BID;
        bus.in_price = '0;
        bus.in_qty   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check("rst_ready", bus.in_ready, 1);
        check("rst_ask_px", best_ask_price, 32'hFFFF_FFFF);
        check("rst_ask_qty", best_ask_qty, 0);
        check("rst_bid_px", best_bid_price, 0);
        check("rst_bid_lv", bid_levels, 0);
        check("rst_ask_lv", ask_levels, 0);
        check("rst_tob_valid", tob_valid, 0);
        check("rst_tob_chg", tob_changed, 0);
        check("rst_upd", update_count, 0);
        check("rst_drop", drop_count, 0);

        // First update with latency checks.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = ADD; bus.in_side = BID;
        bus.in_price = 100;  bus.in_qty = 5;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("cmp_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("apply_ready_low", bus.in_ready, 0);
        check("no_early_bid", best_bid_price, 0);
        @(posedge clk);
        #1;
        exp_upd = 1;
        check("first_bid_px", best_bid_price, 100);
        check("first_bid_qty", best_bid_qty, 5);
        check("first_bid_lv", bid_levels, 1);
        check("first_chg", tob_changed, 1);
        check("first_tob_valid", tob_valid, 0);
        check("first_upd", update_count, 1);
        @(posedge clk);
        #1 check("chg_one_cycle", tob_changed, 0);

        // Sorting and aggregation.
        send(ADD, BID, 102, 3, 0);
        check("b102_px", best_bid_price, 102);
        check("b102_chg", tob_changed, 1);
        send(ADD, BID, 101, 7, 0);
        check("b101_chg", tob_changed, 0);
        send(ADD, BID, 100, 2, 0);
        check("merge_lv", bid_levels, 3);
        check("merge_best_px", best_bid_price, 102);
        check("merge_best_qty", best_bid_qty, 3);
        check("merge_chg", tob_changed, 0);
        send(RED, BID, 102, 3, 0);
        check("del102_px", best_bid_price, 101);
        check("del102_qty", best_bid_qty, 7);
        send(RED, BID, 101, 7, 0);
        check("del101_px", best_bid_price, 100);
        check("agg100_qty", best_bid_qty, 7);
        check("del101_lv", bid_levels, 1);
        send(ADD, BID, 100, 0, 1);
        check("zero_qty_qty", best_bid_qty, 7);

        // Full side, eviction and drop of a worse price.
        send(CLA, BID, 0, 0, 0);
        check("cla_bid_lv", bid_levels, 0);
        check("cla_bid_px", best_bid_price, 0);
        send(ADD, BID, 101, 1, 0);
        send(ADD, BID, 103, 1, 0);
        send(ADD, BID, 104, 1, 0);
        send(ADD, BID, 102, 1, 0);
        check("full_lv", bid_levels, 4);
        check("full_px", best_bid_price, 104);
        send(ADD, BID, 105, 1, 0);
        check("evict_px", best_bid_price, 105);
        check("evict_lv", bid_levels, 4);
        send(ADD, BID, 99, 1, 1);
        check("worse_px", best_bid_price, 105);
        check("worse_lv", bid_levels, 4);
        check("worse_chg", tob_changed, 0);
        send(RED, BID, 105, 1, 0);
        check("walk_104", best_bid_price, 104);
        send(RED, BID, 104, 5, 0);
        check("walk_103", best_bid_price, 103);
        send(RED, BID, 103, 1, 0);
        check("walk_102", best_bid_price, 102);
        check("walk_lv", bid_levels, 1);
        send(RED, BID, 101, 1, 1);
        check("evicted_lv", bid_levels, 1);
        send(RED, BID, 102, 1, 0);
        check("empty_lv", bid_levels, 0);
        check("empty_px", best_bid_price, 0);

        // Ask side reduce/delete.
        send(ADD, ASK, 201, 6, 0);
        check("a201_px", best_ask_price, 201);
        send(ADD, ASK, 200, 4, 0);
        check("a200_px", best_ask_price, 200);
        check("a_lv2", ask_levels, 2);
        send(RED, ASK, 200, 1, 0);
        check("ared_qty", best_ask_qty, 3);
        send(RED, ASK, 200, 10, 0);
        check("adel_px", best_ask_price, 201);
        check("adel_qty", best_ask_qty, 6);
        check("adel_lv", ask_levels, 1);
        send(RED, ASK, 250, 1, 1);
        check("amiss_lv", ask_levels, 1);

        // Clears and tob_valid.
        send(ADD, BID, 150, 2, 0);
        check("tob_valid_on", tob_valid, 1);
        send(CLS, ASK, 0, 0, 0);
        check("cls_ask_lv", ask_levels, 0);
        check("cls_ask_px", best_ask_price, 32'hFFFF_FFFF);
        check("cls_ask_qty", best_ask_qty, 0);
        check("cls_tob_valid", tob_valid, 0);
        check("cls_chg", tob_changed, 1);
        check("cls_bid_kept", bid_levels, 1);
        send(CLS, ASK, 0, 0, 0);
        check("cls_empty_chg", tob_changed, 0);
        send(CLA, ASK, 0, 0, 0);
        check("cla2_bid_lv", bid_levels, 0);
        check("cla2_bid_px", best_bid_price, 0);

        // Saturation and crossed book.
        send(ADD, BID, 300, 32'hFFFF_FFF0, 0);
        send(ADD, BID, 300, 32'h20, 0);
        check("sat_qty", best_bid_qty, 32'hFFFF_FFFF);
        send(ADD, BID, 300, 1, 0);
        check("sat_hold_chg", tob_changed, 0);
        send(ADD, ASK, 250, 1, 0);
        check("cross_ask_px", best_ask_price, 250);
        check("cross_bid_px", best_bid_price, 300);
        check("cross_tob_valid", tob_valid, 1);

        // in_valid held: exactly one acceptance per three cycles.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = ADD; bus.in_side = BID;
        bus.in_price = 50;   bus.in_qty = 1;
        repeat (6) @(posedge clk);
        #1 bus.in_valid = 1'b0;
        exp_upd += 2;
        check("held_upd", update_count, exp_upd);
        check("held_lv", bid_levels, 2);
        send(RED, BID, 50, 2, 0);
        check("held_qty2_del", bid_levels, 1);

        // Reset asserted while the update sits in CMP.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = ADD; bus.in_side = BID;
        bus.in_price = 400;  bus.in_qty = 1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1;
        exp_upd = 0;
        exp_drop = 0;
        check("mid_rst_ready", bus.in_ready, 1);
        check("mid_rst_upd", update_count, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_bid_lv", bid_levels, 0);
        check("mid_rst_ask_px", best_ask_price, 32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        check("no_inflight_lv", bid_levels, 0);
        check("no_inflight_px", best_bid_price, 0);
        check("no_inflight_upd", update_count, 0);
        send(ADD, ASK, 10, 1, 0);
        check("post_rst_ask", best_ask_price, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
